apad_share_arb: RTL and testbench

- Shares one analog pad channel (APRIO-class pass-through pad, analog test/probe net) among NREQ on-chip analog requesters.
- Drives one-hot enables for the analog transmission gates that connect each requester to the pad net.
- Enforces break-before-make dead time and a settle interval before granting.
- Round-robin fair, with optional forced release after a maximum hold time; sits in the digital core beside the analog IO ring.

---
 rtl/apad_share_arb.sv | 148 ++++++++++++++
 tb/tb_apad_share_arb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apad_share_arb.sv
// Round-robin arbiter sharing one analog pad net among NREQ requesters,
// with break-before-make dead time, switch settle delay and optional hold limit.
module apad_share_arb #(
    parameter int NREQ       = 4,
    parameter int SETTLE_CYC = 8,
    parameter int DEAD_CYC   = 4,
    parameter int MAX_HOLD   = 0,
    parameter int CW         = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         sw_en,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    preempt
);

    localparam int OW = $clog2(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_OWN,
        ST_BREAK
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [OW-1:0]   ptr, ptr_nx, owner_nx, win;
    logic            win_vld;
    logic [OW:0]     idx;
    logic [NREQ-1:0] sw_en_nx, gnt_nx, own_mask;
    logic            busy_nx, preempt_nx, others;

    // Lowest offset from ptr+1 wins, so the loop runs downward and the last hit is kept.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int unsigned i = NREQ; i >= 1; i--) begin
            idx = {1'b0, ptr} + (OW+1)'(i);
            if (idx >= (OW+1)'(NREQ))
                idx = idx - (OW+1)'(NREQ);
            if (req[idx[OW-1:0]]) begin
                win     = idx[OW-1:0];
                win_vld = 1'b1;
            end
        end
    end

    assign own_mask = NREQ'(1) << owner;
    assign others   = |(req & ~own_mask);

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        ptr_nx     = ptr;
        owner_nx   = owner;
        sw_en_nx   = sw_en;
        gnt_nx     = gnt;
        preempt_nx = 1'b0;
        case (state)
            ST_IDLE: begin
                sw_en_nx = '0;
                gnt_nx   = '0;
                if (win_vld) begin
                    state_nx = ST_SETTLE;
                    cnt_nx   = '0;
                    sw_en_nx = NREQ'(1) << win;
                    owner_nx = win;
                    ptr_nx   = win;
                end
            end
            ST_SETTLE: begin
                if (!req[owner]) begin
                    state_nx = ST_BREAK;
                    cnt_nx   = '0;
                    sw_en_nx = '0;
                end else if (cnt == CW'(SETTLE_CYC-1)) begin
                    state_nx = ST_OWN;
                    // hold count includes the first granted cycle
                    cnt_nx   = CW'(1);
                    gnt_nx   = own_mask;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_OWN: begin
                if (!req[owner]) begin
                    state_nx = ST_BREAK;
                    cnt_nx   = '0;
                    sw_en_nx = '0;
                    gnt_nx   = '0;
                end else if (MAX_HOLD != 0 && cnt >= CW'(MAX_HOLD) && others) begin
                    state_nx   = ST_BREAK;
                    cnt_nx     = '0;
                    sw_en_nx   = '0;
                    gnt_nx     = '0;
                    preempt_nx = 1'b1;
                end else if (cnt != '1) begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ST_BREAK: begin
                sw_en_nx = '0;
                gnt_nx   = '0;
                if (cnt == CW'(DEAD_CYC-1)) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
                sw_en_nx = '0;
                gnt_nx   = '0;
            end
        endcase
        busy_nx = (state_nx != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            ptr     <= OW'(NREQ-1);
            owner   <= '0;
            sw_en   <= '0;
            gnt     <= '0;
            busy    <= 1'b0;
            preempt <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            ptr     <= ptr_nx;
            owner   <= owner_nx;
            sw_en   <= sw_en_nx;
            gnt     <= gnt_nx;
            busy    <= busy_nx;
            preempt <= preempt_nx;
        end
    end

endmodule

// File: tb/tb_apad_share_arb.sv
// Scoreboard bench for apad_share_arb: one unlimited-hold and one MAX_HOLD=16
// instance share stimulus; a phase/countdown reference model predicts each cycle.
module tb_apad_share_arb;

    localparam int N      = 4;
    localparam int SETTLE = 8;
    localparam int DEAD   = 4;
    localparam int MH1    = 16;

    localparam int P_IDLE = 0;
    localparam int P_SET  = 1;
    localparam int P_OWN  = 2;
    localparam int P_DEAD = 3;

    typedef struct packed {
        logic [N-1:0] sw;
        logic [N-1:0] gn;
        logic         busy;
        logic [1:0]   own;
        logic         pre;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;

    logic [N-1:0] sw0, gn0, sw1, gn1;
    logic         busy0, busy1, pre0, pre1;
    logic [1:0]   own0, own1;

    apad_share_arb #(.NREQ(N), .SETTLE_CYC(SETTLE), .DEAD_CYC(DEAD), .MAX_HOLD(0), .CW(8)) u0 (
        .clk(clk), .rst(rst), .req(req), .sw_en(sw0), .gnt(gn0),
        .busy(busy0), .owner(own0), .preempt(pre0)
    );

    apad_share_arb #(.NREQ(N), .SETTLE_CYC(SETTLE), .DEAD_CYC(DEAD), .MAX_HOLD(MH1), .CW(8)) u1 (
        .clk(clk), .rst(rst), .req(req), .sw_en(sw1), .gnt(gn1),
        .busy(busy1), .owner(own1), .preempt(pre1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    exp_t q0[$];
    exp_t q1[$];

    // reference model state, one slot per instance
    int mph[2], mtmr[2], mhold[2], mown[2], mrr[2], mpre[2];

    task automatic step(input int m, input int mh, input logic r, input logic [N-1:0] rq,
                        output exp_t e);
        int c;
        bit found;
        mpre[m] = 0;
        if (r) begin
            mph[m]  = P_IDLE;
            mown[m] = 0;
            mrr[m]  = N - 1;
        end else begin
            case (mph[m])
                P_IDLE: if (rq != 0) begin
                    found = 0;
                    for (int k = 1; k <= N; k++) begin
                        c = (mrr[m] + k) % N;
                        if (!found && rq[c[1:0]]) begin
                            mown[m] = c;
                            found   = 1;
                        end
                    end
                    mrr[m]  = mown[m];
                    mph[m]  = P_SET;
                    mtmr[m] = SETTLE;
                end
                P_SET: begin
                    c = mown[m];
                    if (!rq[c[1:0]]) begin
                        mph[m]  = P_DEAD;
                        mtmr[m] = DEAD;
                    end else begin
                        mtmr[m]--;
                        if (mtmr[m] == 0) begin
                            mph[m]   = P_OWN;
                            mhold[m] = 1;
                        end
                    end
                end
                P_OWN: begin
                    c = mown[m];
                    if (!rq[c[1:0]]) begin
                        mph[m]  = P_DEAD;
                        mtmr[m] = DEAD;
                    end else if (mh > 0 && mhold[m] >= mh && (rq & ~(N'(1) << mown[m])) != 0) begin
                        mph[m]  = P_DEAD;
                        mtmr[m] = DEAD;
                        mpre[m] = 1;
                    end else if (mhold[m] < 255) begin
                        mhold[m]++;
                    end
                end
                default: begin
                    mtmr[m]--;
                    if (mtmr[m] == 0) mph[m] = P_IDLE;
                end
            endcase
        end
        e.sw   = (mph[m] == P_SET || mph[m] == P_OWN) ? N'(1) << mown[m] : '0;
        e.gn   = (mph[m] == P_OWN) ? N'(1) << mown[m] : '0;
        e.busy = (mph[m] != P_IDLE);
        e.own  = 2'(mown[m]);
        e.pre  = (mpre[m] != 0);
    endtask

    // drive one cycle at the falling edge and queue what the next rising edge must produce
    task automatic cyc(input logic r, input logic [N-1:0] rq);
        exp_t e;
        @(negedge clk);
        rst = r;
        req = rq;
        step(0, 0, r, rq, e);
        q0.push_back(e);
        step(1, MH1, r, rq, e);
        q1.push_back(e);
    endtask

    task automatic check(input int d, input exp_t e, input exp_t a);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL out%0d t=%0t got sw=%b gnt=%b busy=%b owner=%0d pre=%b want sw=%b gnt=%b busy=%b owner=%0d pre=%b",
                     d, $time, a.sw, a.gn, a.busy, a.own, a.pre, e.sw, e.gn, e.busy, e.own, e.pre);
        end
    endtask

    int           cycn = 0;
    int           last_fall[2] = '{-1000, -1000};
    logic [N-1:0] prev_sw[2] = '{'0, '0};

    task automatic invariants(input int d, input logic [N-1:0] sw, input logic [N-1:0] gn);
        total++;
        if (!$onehot0(sw)) begin
            bad++;
            $display("FAIL onehot%0d t=%0t sw=%b want one-hot or zero", d, $time, sw);
        end
        total++;
        if ((gn & ~sw) != 0) begin
            bad++;
            $display("FAIL gnt_sw%0d t=%0t gnt=%b sw=%b want gnt within sw", d, $time, gn, sw);
        end
        if (rst) begin
            last_fall[d] = -1000;
        end else begin
            if (prev_sw[d] != 0 && sw == 0) last_fall[d] = cycn;
            if (prev_sw[d] == 0 && sw != 0 && last_fall[d] >= 0) begin
                total++;
                if (cycn - last_fall[d] < DEAD + 1) begin
                    bad++;
                    $display("FAIL gap%0d t=%0t gap=%0d want>=%0d", d, $time, cycn - last_fall[d], DEAD + 1);
                end
            end
        end
        prev_sw[d] = sw;
    endtask

    // monitor: compares right after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cycn++;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check(0, e, {sw0, gn0, busy0, own0, pre0});
                invariants(0, sw0, gn0);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check(1, e, {sw1, gn1, busy1, own1, pre1});
                invariants(1, sw1, gn1);
            end
        end
    end

    initial begin
        logic [N-1:0] rq, drop;
        int age;
        for (int m = 0; m < 2; m++) begin
            mph[m] = P_IDLE; mtmr[m] = 0; mhold[m] = 0; mown[m] = 0; mrr[m] = N - 1; mpre[m] = 0;
        end
        repeat (3) cyc(1'b1, '0);

        // single requester: grant after settle, release, dead time
        repeat (20) cyc(1'b0, 4'b0001);
        repeat (10) cyc(1'b0, 4'b0000);

        // all requesting, each drops after 5 granted cycles
        drop = '0;
        age  = 0;
        repeat (110) begin
            cyc(1'b0, 4'b1111 & ~drop);
            if (mph[0] == P_OWN) age++; else age = 0;
            if (age == 5) drop = N'(1) << mown[0];
            if (mph[0] == P_DEAD) drop = '0;
        end
        repeat (10) cyc(1'b0, 4'b0000);

        // short pulse aborts during settle
        repeat (3) cyc(1'b0, 4'b0100);
        repeat (10) cyc(1'b0, 4'b0000);

        // contention against hold limit, then sole holder
        repeat (80) cyc(1'b0, 4'b0011);
        repeat (50) cyc(1'b0, 4'b0001);
        repeat (10) cyc(1'b0, 4'b0000);

        // reset while owning, then full contention
        repeat (15) cyc(1'b0, 4'b0100);
        cyc(1'b1, 4'b1111);
        repeat (20) cyc(1'b0, 4'b1111);
        repeat (10) cyc(1'b0, 4'b0000);

        // random level requests with rare resets
        rq = '0;
        repeat (10000) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 15) == 0) rq[b] = ~rq[b];
            cyc($urandom_range(0, 1999) == 0, rq);
        end
        repeat (5) cyc(1'b0, 4'b0000);

        @(posedge clk);
        #2;
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL drain got q0=%0d q1=%0d want 0", q0.size(), q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
